// File: rtl/seven_seg_scan_ctrl_pkg.sv
// seven_seg_scan_ctrl_pkg: shared FSM encodings, display constants and anode helper for the 7-seg scanner
package seven_seg_scan_ctrl_pkg;
  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;
  localparam int NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction
endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if: display-value write port and board display pins of the 7-seg scanner
interface seven_seg_scan_ctrl_if;
  import seven_seg_scan_ctrl_pkg::*;
  logic enable;
  logic wr_en;
  logic [15:0] wr_data;
  logic [6:0] segments;
  logic [NUM_DIGITS-1:0] t;
  logic frame_done;
  modport master (output enable, wr_en, wr_data, input segments, t, frame_done);
  modport slave (input enable, wr_en, wr_data, output segments, t, frame_done);
endinterface

// File: rtl/seven_seg_scan_ctrl_bin_to_hex.sv
// seven_seg_scan_ctrl_bin_to_hex: nibble to active-low {a,b,c,d,e,f,g} hex segment decoder
module seven_seg_scan_ctrl_bin_to_hex (
  input  logic       w_i,
  input  logic       x_i,
  input  logic       y_i,
  input  logic       z_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'b1111111;
    case ({w_i, x_i, y_i, z_i})
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'ha: seg_o = 7'b0001000;
      4'hb: seg_o = 7'b1100000;
      4'hc: seg_o = 7'b0110001;
      4'hd: seg_o = 7'b1000010;
      4'he: seg_o = 7'b0110000;
      default: seg_o = 7'b0111000;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 4-digit multiplexed 7-seg scanner with per-slot anode guard and frame-synchronous updates.
// Define SEG_LEADING_ZERO_BLANK_EN to keep leading-zero digits 1..3 dark.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input logic clk,
  input logic rst_n,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES == 0 ? 0 : BLANK_CYCLES - 1);
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("BLANK_CYCLES must be < REFRESH_DIV");
  end
  logic [0:0] state_q, state_d;
  logic [1:0] digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] active_q, active_d, shadow_q, shadow_d;
  logic pending_q, pending_d;
  logic [3:0] nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0] t_q, t_d;
  logic frame_done_q, frame_done_d;
  logic slot_end, wrap, lz_off;
  logic [6:0] seg;
  assign slot_end = state_q == S_DRIVE && cnt_q == CNT_LAST;
  assign wrap = bus.enable && slot_end && digit_q == 2'(NUM_DIGITS - 1);
  always_comb begin
    state_d = !bus.enable || slot_end ? S_BLANK
            : state_q == S_BLANK && cnt_q == BLANK_LAST ? S_DRIVE : state_q;
    cnt_d = !bus.enable || slot_end ? '0 : cnt_q + 1'b1;
    digit_d = !bus.enable ? 2'd0 : slot_end ? digit_q + 2'd1 : digit_q;
    nibble_d = bus.enable && state_q == S_BLANK ? active_q[{digit_q, 2'b00} +: 4] : nibble_q;
  end
  // While idle or at the frame wrap a write goes straight to the displayed value.
  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    pending_d = pending_q;
    if (bus.wr_en && (!bus.enable || wrap)) begin
      active_d = bus.wr_data;
      pending_d = 1'b0;
    end else if (bus.wr_en) begin
      shadow_d = bus.wr_data;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      active_d = shadow_q;
      pending_d = 1'b0;
    end
  end
  always_comb begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lz_off = digit_d != 2'd0 && (active_q >> {digit_d, 2'b00}) == 16'd0;
`else
    lz_off = 1'b0;
`endif
    t_d = state_d == S_DRIVE && !lz_off ? anode_sel(digit_d) : ANODE_OFF;
    frame_done_d = state_d == S_DRIVE && cnt_d == CNT_LAST && digit_d == 2'(NUM_DIGITS - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BLANK;
      digit_q <= '0;
      cnt_q <= '0;
      active_q <= '0;
      shadow_q <= '0;
      pending_q <= 1'b0;
      nibble_q <= '0;
      t_q <= ANODE_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      nibble_q <= nibble_d;
      t_q <= t_d;
      frame_done_q <= frame_done_d;
    end
  end
  seven_seg_scan_ctrl_bin_to_hex u_dec (
    .w_i(nibble_q[3]),
    .x_i(nibble_q[2]),
    .y_i(nibble_q[1]),
    .z_i(nibble_q[0]),
    .seg_o(seg)
  );
  assign bus.segments = seg;
  assign bus.t = t_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed scan, double-buffer, wrap, disable and reset checks against a timeline model
module tb_seven_seg_scan_ctrl;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = RD * 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  logic clk;
  logic rst_n;
  int total = 0;
  int bad = 0;
  int m_pos;
  logic [15:0] m_disp, m_stage;
  logic m_has;
  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [3:0] t_lit [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg1234 [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
  seven_seg_scan_ctrl_if bus ();
  seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 2 * FRAME);
    check("fd_wait", 16'(bus.frame_done), 16'd1);
  endtask
  task automatic write(input logic [15:0] v);
    bus.wr_en = 1'b1;
    bus.wr_data = v;
    adv(1);
    bus.wr_en = 1'b0;
  endtask
  function automatic logic [3:0] exp_t(input int p, input logic [15:0] v);
    int s;
    s = (p % FRAME) / RD;
    if (p % RD < BC) return 4'hF;
    if (LZ && s != 0 && (v >> (4 * s)) == 16'd0) return 4'hF;
    return ~(4'b0001 << s);
  endfunction
  // Timeline model: m_pos is the cycle's position within the 32-cycle frame, m_disp the value being shown.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0;
      m_disp <= '0;
      m_stage <= '0;
      m_has <= 1'b0;
    end else if (!bus.enable) begin
      m_pos <= 0;
      if (bus.wr_en) begin
        m_disp <= bus.wr_data;
        m_has <= 1'b0;
      end
    end else begin
      m_pos <= (m_pos + 1) % FRAME;
      if (m_pos == FRAME - 1 && bus.wr_en) begin
        m_disp <= bus.wr_data;
        m_has <= 1'b0;
      end else if (m_pos == FRAME - 1 && m_has) begin
        m_disp <= m_stage;
        m_has <= 1'b0;
      end else if (bus.wr_en) begin
        m_stage <= bus.wr_data;
        m_has <= 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_t", 16'(bus.t), 16'(exp_t(m_pos, m_disp)));
      check("model_fd", 16'(bus.frame_done), 16'(m_pos == FRAME - 1));
      if (m_pos % RD >= BC)
        check("model_seg", 16'(bus.segments), 16'(seg_tab[4'(m_disp >> (4 * (m_pos / RD)))]));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int s;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    adv(2);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      adv(1);
      check("rst_t", 16'(bus.t), 16'hF);
      check("rst_fd", 16'(bus.frame_done), 16'd0);
      check("rst_seg", 16'(bus.segments), 16'b0000001);
    end
    write(16'h1234);
    bus.enable = 1'b1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      adv(1);
      s = (k % FRAME) / RD;
      if (k % RD == 1) check("guard_t", 16'(bus.t), 16'hF);
      if (k % RD == 4) begin
        check("drive_t", 16'(bus.t), 16'(t_lit[s]));
        check("digit_seg", 16'(bus.segments), 16'(seg1234[s]));
      end
      if (k % FRAME == FRAME - 1) check("frame_done", 16'(bus.frame_done), 16'd1);
    end
    adv(10);
    write(16'hABCD);
    write(16'h5678);
    adv(7);
    check("torn_d2", 16'(bus.segments), 16'b0010010);
    adv(8);
    check("torn_d3", 16'(bus.segments), 16'b1001111);
    adv(8);
    check("buf_d0", 16'(bus.segments), 16'b0000000);
    adv(8);
    check("buf_d1", 16'(bus.segments), 16'b0001111);
    adv(8);
    check("buf_d2", 16'(bus.segments), 16'b0100000);
    adv(8);
    check("buf_d3", 16'(bus.segments), 16'b0100100);
    wait_fd();
    write(16'h9999);
    for (int d = 0; d < 4; d++) begin
      adv(d == 0 ? 4 : 8);
      check("wrap_seg", 16'(bus.segments), 16'b0000100);
    end
    wait_fd();
    adv(21);
    bus.enable = 1'b0;
    adv(1);
    check("dis_t", 16'(bus.t), 16'hF);
    adv(3);
    bus.enable = 1'b1;
    adv(1);
    check("reen_guard", 16'(bus.t), 16'hF);
    adv(1);
    check("reen_d0_t", 16'(bus.t), 16'b1110);
    adv(10);
    write(16'h4321);
    adv(7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_t", 16'(bus.t), 16'hF);
    check("arst_fd", 16'(bus.frame_done), 16'd0);
    check("arst_seg", 16'(bus.segments), 16'b0000001);
    adv(2);
    rst_n = 1'b1;
    adv(4);
    check("arst_d0_t", 16'(bus.t), 16'b1110);
    check("arst_d0_seg", 16'(bus.segments), 16'b0000001);
    adv(FRAME + 8);
    check("pend_lost", 16'(bus.segments), 16'b0000001);
    write(16'h0042);
    wait_fd();
    adv(5);
    check("v42_d0_t", 16'(bus.t), 16'b1110);
    check("v42_d0_seg", 16'(bus.segments), 16'b0010010);
    adv(8);
    check("v42_d1_t", 16'(bus.t), 16'b1101);
    check("v42_d1_seg", 16'(bus.segments), 16'b1001100);
    adv(8);
    check("v42_d2_t", 16'(bus.t), LZ ? 16'hF : 16'b1011);
    adv(8);
    check("v42_d3_t", 16'(bus.t), LZ ? 16'hF : 16'b0111);
    write(16'h0000);
    wait_fd();
    adv(5);
    check("v0_d0_t", 16'(bus.t), 16'b1110);
    check("v0_d0_seg", 16'(bus.segments), 16'b0000001);
    adv(8);
    check("v0_d1_t", 16'(bus.t), LZ ? 16'hF : 16'b1101);
    adv(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
